// File: rtl/or1200_mem_arb.sv
// Arbiter sharing one single-port synchronous RAM between the OR1200 fetch and data ports.
// Optional fetch starvation guard: define OR1200_ARB_STARVE_GUARD_EN.
module or1200_mem_arb #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ack,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

  state_t r_state, w_state_nxt;
  logic   r_owner;  // 1 = data port owns the current access
  logic   r_wr;
  logic   w_arb, w_gnt_d, w_gnt_i, w_force_i;

  assign w_arb   = (r_state == IDLE) || (r_state == RESP);
  assign w_gnt_d = w_arb && d_req && !w_force_i;
  assign w_gnt_i = w_arb && i_req && !w_gnt_d;

`ifdef OR1200_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] r_starve_cnt;

  assign w_force_i = i_req && (r_starve_cnt == SW'(STARVE_MAX));

  // Counts arbitrations fetch lost while requesting; any fetch win or idle fetch resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
    end else if (w_arb) begin
      if (w_gnt_i || !i_req)
        r_starve_cnt <= '0;
      else if (r_starve_cnt != SW'(STARVE_MAX))
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force_i = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, RESP: w_state_nxt = (w_gnt_d || w_gnt_i) ? ACC : IDLE;
      ACC:        w_state_nxt = r_wr ? IDLE : RESP;
      default:    w_state_nxt = IDLE;
    endcase
  end

  // RAM controls are strobes: cleared every cycle unless a grant reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_wr      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      mem_re  <= 1'b0;
      mem_we  <= 1'b0;
      if (w_gnt_d) begin
        r_owner   <= 1'b1;
        r_wr      <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        mem_re    <= !d_we;
        mem_we    <= d_we;
      end else if (w_gnt_i) begin
        r_owner  <= 1'b0;
        r_wr     <= 1'b0;
        mem_addr <= i_addr;
        mem_re   <= 1'b1;
      end
    end
  end

  assign i_ack    = (r_state == ACC)  && !r_owner;
  assign d_ack    = (r_state == ACC)  &&  r_owner;
  assign i_rvalid = (r_state == RESP) && !r_owner;
  assign d_rvalid = (r_state == RESP) &&  r_owner;
  assign i_rdata  = mem_rdata;
  assign d_rdata  = mem_rdata;

endmodule
